// File: rtl/regfile_wb_arbiter.sv
// Register file writeback arbiter: round-robin share of the single write
// port among NREQ requesters, plus a per-register pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata,
  output logic [2:0]           grant_id,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  output logic [2**AW-1:0]     busy
);

  logic [AW-1:0]     addr [8];
  logic [DW-1:0]     data [8];
  logic [7:0]        nz;
  logic [2:0]        ptr;
  logic [2:0]        ptr_nxt;
  logic [2:0]        win;
  logic              gnt;
  logic [3:0]        slot;
  logic [2**AW-1:0]  busy_nxt;

  // Pad to 8 lanes so a 3-bit index always fits exactly.
  for (genvar i = 0; i < 8; i++) begin : g_lane
    if (i < NREQ) begin : g_req
      assign addr[i] = req_addr[i*AW +: AW];
      assign data[i] = req_data[i*DW +: DW];
      assign nz[i]   = req_valid[i] && (addr[i] != '0);
      assign req_ready[i] = !rst && req_valid[i] &&
        ((addr[i] == '0) || (gnt && (win == 3'(i))));
    end else begin : g_pad
      assign addr[i] = '0;
      assign data[i] = '0;
      assign nz[i]   = 1'b0;
    end
  end

  always_comb begin
    gnt  = 1'b0;
    win  = 3'd0;
    slot = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      slot = {1'b0, ptr} + 4'(k);
      if (slot >= 4'(NREQ))
        slot = slot - 4'(NREQ);
      if (!gnt && nz[slot[2:0]]) begin
        gnt = 1'b1;
        win = slot[2:0];
      end
    end
  end

  assign ptr_nxt = (win == 3'(NREQ-1)) ? 3'd0 : win + 3'd1;

  // A new reservation overrides the clear of the same register.
  always_comb begin
    busy_nxt = busy;
    if (rf_we)
      busy_nxt[rf_waddr] = 1'b0;
    if (rsv_valid && (rsv_addr != '0))
      busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      grant_id <= 3'd0;
      ptr      <= 3'd0;
      busy     <= '0;
    end else begin
      rf_we <= gnt;
      if (gnt) begin
        rf_waddr <= addr[win];
        rf_wdata <= data[win];
        grant_id <= win;
        ptr      <= ptr_nxt;
      end
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus
// randomized traffic against a behavioural round-robin/scoreboard model.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                rf_we;
  logic [AW-1:0]       rf_waddr;
  logic [DW-1:0]       rf_wdata;
  logic [2:0]          grant_id;
  logic                rsv_valid;
  logic [AW-1:0]       rsv_addr;
  logic [31:0]         busy;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [2:0]  m_gid;
  logic [31:0] m_busy;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .grant_id(grant_id),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] a_of(int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [31:0] d_of(int i);
    return req_data[i*DW +: DW];
  endfunction

  task automatic set_req(int i, bit v, logic [4:0] a, logic [31:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_we = 0; m_waddr = 0;
    m_wdata = 0; m_gid = 0; m_busy = 0;
  endtask

  function automatic int m_winner();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i] && a_of(i) != 0) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] m_ready();
    logic [NREQ-1:0] r;
    int w;
    r = '0;
    if (rst) return r;
    w = m_winner();
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && (a_of(i) == 0 || i == w)) r[i] = 1'b1;
    return r;
  endfunction

  // One clock edge; the model advances alongside the DUT.
  task automatic step();
    int w;
    w = m_winner();
    @(posedge clk);
    if (m_we) m_busy[m_waddr] = 1'b0;
    if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    if (w >= 0) begin
      m_we = 1; m_waddr = a_of(w); m_wdata = d_of(w);
      m_gid = 3'(w); m_ptr = (w + 1) % NREQ;
    end else begin
      m_we = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; rsv_valid = 0; rsv_addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    set_req(1, 1, 5'd7, 32'hDEAD_BEEF);
    #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_bad++;
      $display("FAIL rst_ready got %b want 000", req_ready); end
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata, grant_id} !== '0) begin n_bad++;
      $display("FAIL rst_out got we=%b a=%0d d=%h g=%0d want 0",
               rf_we, rf_waddr, rf_wdata, grant_id); end
    n_cmp++; if (busy !== 32'h0) begin n_bad++;
      $display("FAIL rst_busy got %h want 0", busy); end
    model_reset();
    @(negedge clk);
    rst = 0;
    rsv_valid = 1; rsv_addr = 5'd3;
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_bad++;
      $display("FAIL rst_pre_ready got %b want 010", req_ready); end
    step();
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin n_bad++;
      $display("FAIL rst_pre_we got we=%b a=%0d want 1/7", rf_we, rf_waddr); end
    rst = 1;
    #1;
    n_cmp++; if (rf_we !== 1'b0 || busy !== 32'h0 || req_ready !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_mid got we=%b busy=%h rdy=%b want 0/0/000",
               rf_we, busy, req_ready); end
    model_reset();
    rsv_valid = 0;
    @(negedge clk);
    rst = 0;
    set_req(0, 1, 5'd1, 32'h1);
    set_req(1, 1, 5'd2, 32'h2);
    set_req(2, 1, 5'd3, 32'h3);
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++;
      $display("FAIL rst_ptr0 got %b want 001", req_ready); end
    step();
    n_cmp++; if (grant_id !== 3'd0 || rf_waddr !== 5'd1) begin n_bad++;
      $display("FAIL rst_first got g=%0d a=%0d want 0/1", grant_id, rf_waddr); end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_req(0, 1, 5'd1, 32'h11);
    set_req(1, 1, 5'd2, 32'h22);
    set_req(2, 1, 5'd3, 32'h33);
    for (int k = 0; k < 6; k++) begin
      logic [2:0] er;
      er = 3'(1 << (k % 3));
      #1;
      n_cmp++; if (req_ready !== er) begin n_bad++;
        $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, er); end
      step();
      n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'(k % 3 + 1) ||
                   grant_id !== 3'(k % 3) ||
                   rf_wdata !== 32'(((k % 3) + 1) * 32'h11)) begin
        n_bad++;
        $display("FAIL rr_out[%0d] got we=%b a=%0d g=%0d d=%h want 1/%0d/%0d",
                 k, rf_we, rf_waddr, grant_id, rf_wdata, k % 3 + 1, k % 3); end
    end
  endtask

  task automatic test_x0();
    do_reset();
    set_req(0, 1, 5'd0, 32'h99);
    set_req(1, 1, 5'd4, 32'h44);
    #1;
    n_cmp++; if (req_ready !== 3'b011) begin n_bad++;
      $display("FAIL x0_ready got %b want 011", req_ready); end
    step();
    idle_inputs();
    n_cmp++; if (rf_we !== 1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h44 ||
                 grant_id !== 3'd1) begin n_bad++;
      $display("FAIL x0_write got we=%b a=%0d d=%h g=%0d want 1/4/44/1",
               rf_we, rf_waddr, rf_wdata, grant_id); end
    step();
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++;
      $display("FAIL x0_single got we=%b want 0", rf_we); end
    set_req(0, 1, 5'd1, 32'h1);
    set_req(1, 1, 5'd2, 32'h2);
    set_req(2, 1, 5'd3, 32'h3);
    #1;
    n_cmp++; if (req_ready !== 3'b100) begin n_bad++;
      $display("FAIL x0_ptr got %b want 100", req_ready); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    rsv_valid = 1; rsv_addr = 5'd9;
    step();
    rsv_valid = 0;
    n_cmp++; if (busy[9] !== 1'b1) begin n_bad++;
      $display("FAIL sb_set got %b want 1", busy[9]); end
    set_req(2, 1, 5'd9, 32'h9999);
    step();
    req_valid = '0;
    n_cmp++; if (rf_we !== 1 || rf_waddr !== 5'd9 || busy[9] !== 1'b1) begin
      n_bad++;
      $display("FAIL sb_wr got we=%b a=%0d b9=%b want 1/9/1",
               rf_we, rf_waddr, busy[9]); end
    step();
    n_cmp++; if (busy[9] !== 1'b0) begin n_bad++;
      $display("FAIL sb_clr got %b want 0", busy[9]); end
    rsv_valid = 1; rsv_addr = 5'd9;
    set_req(2, 1, 5'd9, 32'h1234);
    step();
    req_valid = '0;
    step();
    n_cmp++; if (busy[9] !== 1'b1) begin n_bad++;
      $display("FAIL sb_setwins got %b want 1", busy[9]); end
    rsv_addr = 5'd10;
    set_req(0, 1, 5'd9, 32'h5);
    step();
    req_valid = '0;
    rsv_addr = 5'd0;
    step();
    n_cmp++; if (busy !== 32'h0000_0400) begin n_bad++;
      $display("FAIL sb_two got %h want 00000400", busy); end
    step();
    rsv_valid = 0;
    n_cmp++; if (busy[0] !== 1'b0 || busy !== m_busy) begin n_bad++;
      $display("FAIL sb_x0 got %h want %h", busy, m_busy); end
  endtask

  task automatic test_idle_hold();
    do_reset();
    set_req(0, 1, 5'd5, 32'h55);
    step();
    req_valid = '0;
    step();
    n_cmp++; if (rf_we !== 0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h55) begin
      n_bad++;
      $display("FAIL idle_hold got we=%b a=%0d d=%h want 0/5/55",
               rf_we, rf_waddr, rf_wdata); end
    step(); step();
    set_req(0, 1, 5'd1, 32'h1);
    set_req(1, 1, 5'd2, 32'h2);
    set_req(2, 1, 5'd3, 32'h3);
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_bad++;
      $display("FAIL idle_ptr got %b want 010", req_ready); end
  endtask

  task automatic test_hold();
    logic [2:0] exp_r [3];
    exp_r[0] = 3'b010; exp_r[1] = 3'b100; exp_r[2] = 3'b001;
    do_reset();
    set_req(0, 1, 5'd6, 32'h6);
    step();
    set_req(0, 1, 5'd12, 32'hA0A0_A0A0);
    set_req(1, 1, 5'd13, 32'h13);
    set_req(2, 1, 5'd14, 32'h14);
    for (int k = 0; k < 3; k++) begin
      logic [2:0] r;
      #1;
      r = req_ready;
      n_cmp++; if (r !== exp_r[k]) begin n_bad++;
        $display("FAIL hold_ready[%0d] got %b want %b", k, r, exp_r[k]); end
      step();
      for (int i = 0; i < NREQ; i++)
        if (r[i]) req_valid[i] = 1'b0;
    end
    n_cmp++; if (rf_waddr !== 5'd12 || rf_wdata !== 32'hA0A0_A0A0 ||
                 grant_id !== 3'd0) begin n_bad++;
      $display("FAIL hold_out got a=%0d d=%h g=%0d want 12/a0a0a0a0/0",
               rf_waddr, rf_wdata, grant_id); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [2:0] er;
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(2) == 0)
          set_req(i, 1,
                  ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom),
                  $urandom);
      rsv_valid = ($urandom_range(3) == 0);
      rsv_addr = 5'($urandom);
      #1;
      er = m_ready();
      n_cmp++; if (req_ready !== er) begin n_bad++;
        $display("FAIL rnd_ready[%0d] got %b want %b", c, req_ready, er); end
      step();
      n_cmp++; if (rf_we !== m_we || (m_we && (rf_waddr !== m_waddr ||
                   rf_wdata !== m_wdata || grant_id !== m_gid))) begin
        n_bad++;
        $display("FAIL rnd_out[%0d] got we=%b a=%0d d=%h g=%0d want %b/%0d/%h/%0d",
                 c, rf_we, rf_waddr, rf_wdata, grant_id,
                 m_we, m_waddr, m_wdata, m_gid); end
      n_cmp++; if (busy !== m_busy) begin n_bad++;
        $display("FAIL rnd_busy[%0d] got %h want %h", c, busy, m_busy); end
      for (int i = 0; i < NREQ; i++)
        if (er[i]) req_valid[i] = 1'b0;
    end
  endtask

  initial begin
    rst = 1;
    req_valid = '0; req_addr = '0; req_data = '0;
    rsv_valid = 0; rsv_addr = 0;
    model_reset();
    test_reset();
    test_round_robin();
    test_x0();
    test_scoreboard();
    test_idle_hold();
    test_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (write enable, 5-bit write address, 32-bit write data) among NREQ writeback requesters, e.g. ALU, load unit and multiplier.
- Requests use a valid/ready handshake. A round-robin arbiter selects one request per cycle and places it in a registered output stage that drives the register file write port.
- Also keeps a per-register pending-write scoreboard (busy bits) for hazard detection by the issue logic.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- DW, 32, data width.
- AW, 5, register address width (32 registers).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NREQ  request i valid.
- req_addr  input  NREQ*AW  destination register of request i; bits [i*AW +: AW].
- req_data  input  NREQ*DW  write data of request i; bits [i*DW +: DW].
- req_ready  output  NREQ  request i accepted this cycle (combinational).
- rf_we  output  1  register file write enable (registered).
- rf_waddr  output  AW  register file write address (registered).
- rf_wdata  output  DW  register file write data (registered).
- grant_id  output  3  index of the requester whose write is on rf_* this cycle (registered).
- rsv_valid  input  1  issue logic reserves a destination register.
- rsv_addr  input  AW  register being reserved.
- busy  output  2**AW  scoreboard; bit r=1 means a write to r is pending (registered).

Behaviour:
- Reset (async, any time, including mid-transfer):
  - rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, busy=0.
  - Round-robin pointer=0.
  - A request accepted in the cycle of reset assertion is lost.
  - req_ready is 0 while rst=1.
- Handshake:
  - A transfer occurs in any cycle where req_valid[i] && req_ready[i].
  - A requester holds valid, addr and data stable until the transfer. Bench checks this; the DUT does not.
  - req_ready never depends on anything except req_valid, req_addr and the pointer. No combinational path from busy or rsv_*.
- x0 requests (req_addr==0 with valid):
  - req_ready=1 in the same cycle, independent of arbitration.
  - Consumes no write slot and produces no rf_we.
  - Does not move the pointer.
  - Several x0 requests may be accepted in one cycle, alongside one nonzero grant.
- Arbitration among nonzero-address valid requests:
  - Round-robin starting at the pointer p: the first i in order p, p+1, ..., NREQ-1, 0, ..., p-1 with a valid nonzero request wins.
  - Exactly one winner per cycle. req_ready=1 only for the winner (and x0 requesters).
  - After a grant to i, the pointer becomes (i+1) mod NREQ. With no grant the pointer holds.
- Output stage:
  - Latency is 1 cycle. The winner's addr and data appear on rf_waddr/rf_wdata with rf_we=1 in the cycle after acceptance, and grant_id=i.
  - rf_we=0 in a cycle following a cycle with no nonzero grant. rf_waddr and rf_wdata then hold their previous values.
  - Throughput is 1 write/cycle; the stage never stalls.
- Scoreboard:
  - Set: on a rising edge with rsv_valid=1 and rsv_addr!=0, busy[rsv_addr] becomes 1.
  - Clear: on a rising edge with rf_we=1, busy[rf_waddr] becomes 0.
  - Same register set and cleared in the same cycle: set wins, busy stays 1 (new reservation).
  - Set and clear on different registers in the same cycle: both take effect.
  - busy[0] is constantly 0; reserving register 0 is ignored.
  - A write to a non-busy register is legal and leaves its bit 0.
- Simultaneous events are all legal in one cycle: x0 accept, nonzero grant, rf_we of the previous grant, and a reservation.

Test Plan:
- Reset mid-stream: grant req1 (addr 7, data 0xDEAD_BEEF), assert rst in the next cycle before the clock edge -> rf_we=0, busy=0 and req_ready=0 immediately. After release, the pointer is 0 and req0 wins first.
- Round-robin: all three requesters valid continuously with addrs 1/2/3 and data 0x11/0x22/0x33 -> rf_we=1 every cycle from cycle 1, rf_waddr sequence 1,2,3,1,2,3 and grant_id sequence 0,1,2,0,1,2. Each req_ready pulses once per 3 cycles.
- x0 handling: req0 valid with addr 0, req1 valid with addr 4 and data 0x44 -> both ready in the same cycle. Exactly one write follows: rf_waddr=4, rf_wdata=0x44. The pointer moves to 2.
- Scoreboard:
  - rsv_valid for addr 9 -> busy[9]=1 next cycle.
  - req2 writes addr 9 -> busy[9]=0 after the rf_we cycle.
  - Re-reserve 9 in the same cycle rf_we writes 9 -> busy[9] stays 1.
  - Reserve addr 0 -> busy[0] stays 0.
- Idle/hold: requests drop after one write (addr 5, data 0x55) -> next cycle rf_we=0, with rf_waddr=5 and rf_wdata=0x55 held. The pointer does not change while idle.
- Hold check: req0 valid but not granted for 2 cycles because req1/req2 win -> req0 is granted on the third arbitration with its original addr and data written.
